// File: rtl/cfg_width_ctrl.sv
// cfg_width_ctrl: runtime data-width configuration controller.
// Accepts width-change requests on a valid/ready channel and checks that each
// width is legal. For a real change it stalls the datapath and waits for a
// quiet window, then applies the new width atomically. Every request gets a
// one-cycle response.
// Optional macro CFG_WIDTH_ERR_CNT_EN adds an 8-bit saturating error-response
// counter on output err_cnt.
module cfg_width_ctrl #(
  parameter int DEF_WIDTH    = 32,
  parameter int MIN_WIDTH    = 8,
  parameter int MAX_WIDTH    = 64,
  parameter int QUIET_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_wr_valid,
  output logic       cfg_wr_ready,
  input  logic [7:0] cfg_wr_width,
  output logic       cfg_wr_resp_valid,
  output logic       cfg_wr_resp_err,
  input  logic       dp_busy,
  output logic       dp_hold,
`ifdef CFG_WIDTH_ERR_CNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic [7:0] cfg_data_width,
  output logic       cfg_update
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] QUIET_LAST   = CW'(QUIET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0]    MIN_W        = 8'(MIN_WIDTH);
  localparam logic [7:0]    MAX_W        = 8'(MAX_WIDTH);
  localparam logic [7:0]    DEF_W        = 8'(DEF_WIDTH);

  typedef enum logic [1:0] {IDLE, DRAIN, APPLY, RESP} state_t;

  state_t        state;
  logic [CW-1:0] quiet_cnt;
  logic [CW-1:0] drain_cnt;
  logic [7:0]    shadow;

  // A legal width is a nonzero power of two within [MIN_WIDTH, MAX_WIDTH].
  function automatic logic width_legal(input logic [7:0] w);
    logic pow2;
    pow2 = (w != 8'd0) && ((w & (w - 8'd1)) == 8'd0);
    return pow2 && (w >= MIN_W) && (w <= MAX_W);
  endfunction

  // Shadow holds the captured request; it is data and needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_wr_valid && cfg_wr_ready)
      shadow <= cfg_wr_width;
  end

  // Control FSM: all handshake, stall and width outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      cfg_wr_ready      <= 1'b1;
      dp_hold           <= 1'b0;
      cfg_wr_resp_valid <= 1'b0;
      cfg_wr_resp_err   <= 1'b0;
      cfg_update        <= 1'b0;
      cfg_data_width    <= DEF_W;
      quiet_cnt         <= '0;
      drain_cnt         <= '0;
    end else begin
      cfg_wr_resp_valid <= 1'b0;
      cfg_update        <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_wr_valid && cfg_wr_ready) begin
            if (!width_legal(cfg_wr_width)) begin
              state             <= RESP;
              cfg_wr_ready      <= 1'b0;
              cfg_wr_resp_valid <= 1'b1;
              cfg_wr_resp_err   <= 1'b1;
            end else if (cfg_wr_width == cfg_data_width) begin
              state             <= RESP;
              cfg_wr_ready      <= 1'b0;
              cfg_wr_resp_valid <= 1'b1;
              cfg_wr_resp_err   <= 1'b0;
            end else begin
              state        <= DRAIN;
              cfg_wr_ready <= 1'b0;
              dp_hold      <= 1'b1;
              quiet_cnt    <= '0;
              drain_cnt    <= '0;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + CW'(1);
          quiet_cnt <= dp_busy ? '0 : quiet_cnt + CW'(1);
          // Quiet completion takes priority over a coincident timeout.
          if (!dp_busy && quiet_cnt == QUIET_LAST) begin
            state          <= APPLY;
            cfg_data_width <= shadow;
            cfg_update     <= 1'b1;
          end else if (drain_cnt == TIMEOUT_LAST) begin
            state             <= RESP;
            dp_hold           <= 1'b0;
            cfg_wr_resp_valid <= 1'b1;
            cfg_wr_resp_err   <= 1'b1;
          end
        end
        APPLY: begin
          state             <= RESP;
          dp_hold           <= 1'b0;
          cfg_wr_resp_valid <= 1'b1;
          cfg_wr_resp_err   <= 1'b0;
        end
        RESP: begin
          state           <= IDLE;
          cfg_wr_ready    <= 1'b1;
          cfg_wr_resp_err <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CFG_WIDTH_ERR_CNT_EN
  // Count error responses, saturating at 255; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= 8'd0;
    else if (cfg_wr_resp_valid && cfg_wr_resp_err && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cfg_width_ctrl.sv
// Testbench for cfg_width_ctrl: directed cases plus randomized requests,
// checked against a request-level reference model of the controller.
module tb_cfg_width_ctrl;

  localparam int DEF_WIDTH    = 32;
  localparam int MIN_WIDTH    = 8;
  localparam int MAX_WIDTH    = 64;
  localparam int QUIET_CYCLES = 2;
  localparam int TIMEOUT      = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr_valid = 1'b0;
  logic       cfg_wr_ready;
  logic [7:0] cfg_wr_width = 8'd0;
  logic       cfg_wr_resp_valid;
  logic       cfg_wr_resp_err;
  logic       dp_busy = 1'b0;
  logic       dp_hold;
  logic [7:0] cfg_data_width;
  logic       cfg_update;
`ifdef CFG_WIDTH_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cur_w = DEF_WIDTH;
  int err_total = 0;
  bit busy_pat [1:TIMEOUT+2];

  cfg_width_ctrl #(
    .DEF_WIDTH(DEF_WIDTH), .MIN_WIDTH(MIN_WIDTH), .MAX_WIDTH(MAX_WIDTH),
    .QUIET_CYCLES(QUIET_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_wr_valid(cfg_wr_valid),
    .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_width(cfg_wr_width),
    .cfg_wr_resp_valid(cfg_wr_resp_valid),
    .cfg_wr_resp_err(cfg_wr_resp_err),
    .dp_busy(dp_busy),
    .dp_hold(dp_hold),
`ifdef CFG_WIDTH_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .cfg_data_width(cfg_data_width),
    .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal_ref(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ($countones(w) == 1);
  endfunction

  task automatic fill_busy(input int mode);
    for (int i = 1; i <= TIMEOUT + 2; i++) begin
      case (mode)
        0: busy_pat[i] = 1'b0;
        1: busy_pat[i] = 1'b1;
        2: busy_pat[i] = 1'($urandom_range(0, 1));
        default: busy_pat[i] = ($urandom_range(0, 3) == 0);
      endcase
    end
  endtask

  // Issue one request from a negedge in IDLE; checks every cycle until back in IDLE.
  task automatic run_req(input int w);
    int apply_c, resp_c, run;
    bit e, drains;
    apply_c = 0; resp_c = 0; e = 1'b0;
    if (!legal_ref(w)) begin
      resp_c = 1; e = 1'b1;
    end else if (w == cur_w) begin
      resp_c = 1;
    end else begin
      run = 0;
      for (int k = 1; k <= TIMEOUT && resp_c == 0; k++) begin
        run = busy_pat[k] ? 0 : run + 1;
        if (run == QUIET_CYCLES) begin
          apply_c = k + 1; resp_c = k + 2;
        end else if (k == TIMEOUT) begin
          resp_c = k + 1; e = 1'b1;
        end
      end
    end
    drains = (resp_c > 1);

    chk_eq("ready_idle", cfg_wr_ready, 1);
    cfg_wr_valid = 1'b1;
    cfg_wr_width = 8'(w);
    @(posedge clk); #1;
    cfg_wr_valid = 1'b0;
    cfg_wr_width = 8'($urandom);
    for (int n = 1; n <= resp_c + 1; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      dp_busy = busy_pat[n];
      @(negedge clk);
      chk_eq("hold", dp_hold, (drains && n < resp_c) ? 1 : 0);
      chk_eq("width", cfg_data_width, (apply_c != 0 && n >= apply_c) ? w : cur_w);
      chk_eq("update", cfg_update, (n == apply_c) ? 1 : 0);
      chk_eq("resp_valid", cfg_wr_resp_valid, (n == resp_c) ? 1 : 0);
      chk_eq("resp_err", cfg_wr_resp_err, (n == resp_c) ? e : 0);
      chk_eq("ready", cfg_wr_ready, (n > resp_c) ? 1 : 0);
    end
    if (apply_c != 0) cur_w = w;
    if (e && err_total < 255) err_total++;
`ifdef CFG_WIDTH_ERR_CNT_EN
    chk_eq("err_cnt", err_cnt, err_total);
`endif
    dp_busy = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk_eq({tag, "_width"}, cfg_data_width, DEF_WIDTH);
    chk_eq({tag, "_ready"}, cfg_wr_ready, 1);
    chk_eq({tag, "_hold"}, dp_hold, 0);
    chk_eq({tag, "_resp_valid"}, cfg_wr_resp_valid, 0);
    chk_eq({tag, "_resp_err"}, cfg_wr_resp_err, 0);
    chk_eq({tag, "_update"}, cfg_update, 0);
  endtask

  initial begin
    int w;
    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("rst_idle");

    // Illegal widths, then a no-op write of the current width
    fill_busy(0);
    run_req(24);
    run_req(0);
    run_req(128);
    run_req(32);
    // Legal change with a quiet datapath
    run_req(64);
    // Busy pattern 1,0,1,0,0 restarts the quiet window
    fill_busy(0);
    busy_pat[1] = 1'b1; busy_pat[3] = 1'b1;
    run_req(16);
    // Datapath never drains: timeout
    fill_busy(1);
    run_req(8);

    // Reset in the middle of a drain discards the request
    fill_busy(1);
    chk_eq("mid_ready", cfg_wr_ready, 1);
    cfg_wr_valid = 1'b1;
    cfg_wr_width = 8'd8;
    @(posedge clk); #1;
    cfg_wr_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      dp_busy = 1'b1;
      @(negedge clk);
      chk_eq("mid_hold", dp_hold, 1);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dp_busy = 1'b0;
    @(negedge clk);
    chk_reset_state("mid_rst");
    cur_w = DEF_WIDTH;
    err_total = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk_eq("mid_no_resp", cfg_wr_resp_valid, 0);
    end

    // Randomized requests
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 9))
        0: w = 0;
        1: w = 8;
        2: w = 16;
        3: w = 32;
        4: w = 64;
        5: w = 128;
        6: w = 4;
        7: w = 24;
        8: w = cur_w;
        default: w = int'($urandom_range(0, 255));
      endcase
      fill_busy(($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 4)) - ((r % 3 == 0) ? 2 : 0));
      run_req(w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_width_ctrl.md
Name: cfg_width_ctrl

Overview:
Runtime configuration controller for the width-configurable IP datapath. That datapath's width is an input signal, cfg_data_width, not an elaboration parameter. This block accepts width-change requests over a valid/ready write channel and validates them. It stalls the datapath, waits for it to drain, then applies the new width atomically and returns a single-cycle response. It sits between the testbench/UVM sequence (or register bus) and the IP's cfg_data_width input.

Parameters:
DEF_WIDTH, 32, cfg_data_width value after reset; must be a legal width.
MIN_WIDTH, 8, smallest legal width (power of two).
MAX_WIDTH, 64, largest legal width (power of two, <=128).
QUIET_CYCLES, 2, consecutive dp_busy=0 cycles required before apply (>=1).
TIMEOUT, 64, maximum cycles spent in DRAIN before abort (>QUIET_CYCLES).

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
cfg_wr_valid  input  1  width-change request valid
cfg_wr_ready  output  1  request accepted when valid&ready
cfg_wr_width  input  8  requested data width
cfg_wr_resp_valid  output  1  one-cycle response pulse, no backpressure
cfg_wr_resp_err  output  1  qualifies resp_valid; 1 = rejected or timed out
dp_busy  input  1  datapath has transactions in flight
dp_hold  output  1  stall request to the datapath; no new data is accepted while high
cfg_data_width  output  8  width currently applied to the datapath
cfg_update  output  1  one-cycle pulse in the first cycle the new width is visible

Behaviour:
- Clock/reset: single clock clk; rst_n synchronous, active-low.
- Reset values: cfg_data_width=DEF_WIDTH, cfg_wr_ready=1, dp_hold=0, cfg_wr_resp_valid=0, cfg_wr_resp_err=0, cfg_update=0; FSM=IDLE; counters=0.
- Legal width: a power of two with MIN_WIDTH <= w <= MAX_WIDTH. Zero is illegal.
- FSM states: IDLE, DRAIN, APPLY, RESP. All outputs are registered.
- IDLE:
  - ready=1, hold=0.
  - On valid&ready, capture cfg_wr_width into the shadow register.
  - Illegal width -> RESP, err=1.
  - Legal and equal to current width -> RESP, err=0, no cfg_update.
  - Otherwise -> DRAIN with quiet_cnt=0 and drain_cnt=0.
- DRAIN:
  - ready=0, hold=1. drain_cnt increments every cycle.
  - quiet_cnt increments when dp_busy=0 and clears when dp_busy=1.
  - If dp_busy=0 and quiet_cnt==QUIET_CYCLES-1 -> APPLY.
  - Else if drain_cnt==TIMEOUT-1 -> RESP with err=1; width unchanged, no cfg_update.
  - Quiet completion wins over timeout in the same cycle.
- APPLY (1 cycle):
  - cfg_data_width=shadow and cfg_update=1, both registered on entry; hold=1.
  - Next state RESP.
- RESP (1 cycle):
  - resp_valid=1 with err as determined; ready=0, hold=0.
  - Next state IDLE.
- Latency, request accepted in cycle T:
  - Reject or no-op: resp_valid in T+1.
  - Change with dp_busy=0 throughout: DRAIN T+1..T+QUIET_CYCLES, APPLY (new width and cfg_update) T+QUIET_CYCLES+1, resp_valid T+QUIET_CYCLES+2.
  - Timeout: resp_valid, err=1, in T+TIMEOUT+1.
- Outstanding requests: only one at a time. cfg_wr_valid outside IDLE is ignored (ready=0) and must be held by the requester.
- cfg_data_width changes only in APPLY. It never glitches or changes while dp_hold=0.
- Reset mid-operation: the pending request is discarded without a response. All outputs return to reset values the cycle after rst_n is sampled low, including cfg_data_width=DEF_WIDTH.
- Counter widths: $clog2(TIMEOUT+1) bits; counters never wrap within DRAIN.

Optional Feature:
Macro: CFG_WIDTH_ERR_CNT_EN.
- Defined: adds output port err_cnt, 8 bits. Increments by 1 on every response with err=1. Saturates at 255. Cleared only by reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then idle -> cfg_data_width=32, ready=1, hold=0, resp_valid=0, cfg_update=0.
2. Write 64 with dp_busy=0, QUIET_CYCLES=2, accepted at T:
   - hold=1 at T+1..T+3.
   - cfg_data_width=64 and cfg_update=1 at T+3.
   - resp_valid=1, err=0 at T+4.
3. Write 24, then 0, then 128 (each illegal with MAX_WIDTH=64) -> each resp_valid at T+1 with err=1; width stays 32; err_cnt=3 when the macro is defined.
4. Write 32 while the current width is 32 -> resp at T+1, err=0; no hold, no cfg_update.
5. Write 16 with dp_busy pattern 1,0,1,0,0 -> quiet_cnt restarts on each busy cycle; apply occurs after the final two quiet cycles; width=16.
6. Write 8 with dp_busy=1 held, TIMEOUT=64 -> resp err=1 at T+65; hold drops; width unchanged.
   - Second run: assert rst_n=0 at T+10 -> no response; width=DEF_WIDTH; ready=1 after reset.
